// File: rtl/tb_retire_checker.sv
// Generic single-clock FIFO with first-word-fall-through head and synchronous clear.
// Latency: a word pushed at edge N is visible on o_dat after edge N; clear takes effect at the next edge.
// Backpressure: pushes while full and pops while empty are ignored; o_full/o_empty come from a registered count.
module fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rd_ptr];

  // Storage array: written on every accepted push, never reset.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_dat;
  end

  // Pointers and occupancy; a clear empties the FIFO and overrides any push/pop that cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end
endmodule

// In-order retirement checker: compares each retirement with the next expected record and keeps class statistics.
// Latency: a retirement sampled at edge N updates status, error info and counters after edge N.
// Backpressure: o_exp_ready drops while the record FIFO is full or not running; retirements cannot be stalled.
module tb_retire_checker #(
  parameter  int DEPTH          = 16,
  parameter  int TIMEOUT_CYCLES = 10000,
  parameter  int MAX_TESTS      = 1000,
  localparam int CW             = $clog2(MAX_TESTS + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [CW-1:0] i_num_tests,
  input  logic          i_exp_valid,
  output logic          o_exp_ready,
  input  logic [31:0]   i_exp_instr,
  input  logic [31:0]   i_exp_pc,
  input  logic [31:0]   i_exp_result,
  input  logic          i_exp_exception,
  input  logic          i_ret_valid,
  input  logic [31:0]   i_ret_instr,
  input  logic [31:0]   i_ret_pc,
  input  logic [31:0]   i_ret_result,
  input  logic          i_ret_exception,
  output logic          o_busy,
  output logic          o_pass,
  output logic          o_fail,
  output logic          o_timeout,
  output logic [2:0]    o_err_code,
  output logic [CW-1:0] o_fail_index,
  output logic [31:0]   o_cnt_instr,
  output logic [31:0]   o_cnt_branch,
  output logic [31:0]   o_cnt_load,
  output logic [31:0]   o_cnt_store,
  output logic [31:0]   o_cnt_jump,
  output logic [31:0]   o_cnt_exc
);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] result;
    logic        exc;
  } rec_t;

  state_t        r_state;
  state_t        w_state_nxt;
  rec_t          w_push_dat;
  rec_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_run;
  logic          w_push;
  logic          w_chk;
  logic          w_pop;
  logic [CW-1:0] r_num;
  logic [CW-1:0] r_checked;
  logic [CW-1:0] w_checked_inc;
  logic [CW-1:0] w_num_clamped;
  logic [IW-1:0] r_idle;
  logic [IW-1:0] w_idle_inc;
  logic [2:0]    w_err_chk;
  logic [6:0]    w_op;
  logic          w_cmp_res;
  logic [2:0]    r_err;
  logic [CW-1:0] r_fidx;
  logic [31:0]   r_cnt_instr, r_cnt_branch, r_cnt_load, r_cnt_store, r_cnt_jump, r_cnt_exc;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  assign w_run         = (r_state == S_RUN);
  assign w_num_clamped = (i_num_tests > CW'(MAX_TESTS)) ? CW'(MAX_TESTS) : i_num_tests;
  assign o_exp_ready   = w_run && !w_full;
  // start takes priority: a coincident record or retirement is dropped.
  assign w_push        = i_exp_valid && o_exp_ready && !i_start;
  assign w_chk         = i_ret_valid && w_run && !i_start;
  assign w_pop         = w_chk && !w_empty;
  assign w_push_dat    = '{instr: i_exp_instr, pc: i_exp_pc, result: i_exp_result, exc: i_exp_exception};
  assign w_checked_inc = r_checked + CW'(1);
  assign w_idle_inc    = r_idle + IW'(1);
  assign w_op          = i_ret_instr[6:0];
  // Branches and stores write no register, and trapping instructions have no defined result.
  assign w_cmp_res     = (w_op != OP_BRANCH) && (w_op != OP_STORE) && !w_head.exc;

  fifo #(.DEPTH(DEPTH), .W($bits(rec_t))) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_start),
    .i_push  (w_push),
    .i_dat   (w_push_dat),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Field comparison against the FIFO head, first mismatch in pc/instr/exception/result order wins.
  always_comb begin
    w_err_chk = 3'd0;
    if (i_ret_pc != w_head.pc)                         w_err_chk = 3'd1;
    else if (i_ret_instr != w_head.instr)              w_err_chk = 3'd2;
    else if (i_ret_exception != w_head.exc)            w_err_chk = 3'd3;
    else if (w_cmp_res && (i_ret_result != w_head.result)) w_err_chk = 3'd4;
  end

  // Run-state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: start restarts from anywhere; terminal states hold until the next start.
  always_comb begin
    w_state_nxt = r_state;
    if (i_start) begin
      w_state_nxt = (w_num_clamped == '0) ? S_PASS : S_RUN;
    end else if (w_run) begin
      if (i_ret_valid) begin
        if (w_empty || (w_err_chk != 3'd0)) w_state_nxt = S_FAIL;
        else if (w_checked_inc == r_num)    w_state_nxt = S_PASS;
      end else if (w_idle_inc == IW'(TIMEOUT_CYCLES)) begin
        w_state_nxt = S_TIMEOUT;
      end
    end
  end

  // Progress, idle timer, error capture and class statistics.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_num        <= '0;
      r_checked    <= '0;
      r_idle       <= '0;
      r_err        <= '0;
      r_fidx       <= '0;
      r_cnt_instr  <= '0;
      r_cnt_branch <= '0;
      r_cnt_load   <= '0;
      r_cnt_store  <= '0;
      r_cnt_jump   <= '0;
      r_cnt_exc    <= '0;
    end else if (i_start) begin
      r_num        <= w_num_clamped;
      r_checked    <= '0;
      r_idle       <= '0;
      r_err        <= '0;
      r_fidx       <= '0;
      r_cnt_instr  <= '0;
      r_cnt_branch <= '0;
      r_cnt_load   <= '0;
      r_cnt_store  <= '0;
      r_cnt_jump   <= '0;
      r_cnt_exc    <= '0;
    end else if (w_run) begin
      if (i_ret_valid) begin
        r_idle <= '0;
        if (w_empty) begin
          r_err  <= 3'd5;
          r_fidx <= r_checked;
        end else begin
          r_cnt_instr  <= sat_inc(r_cnt_instr, 1'b1);
          r_cnt_branch <= sat_inc(r_cnt_branch, w_op == OP_BRANCH);
          r_cnt_load   <= sat_inc(r_cnt_load, w_op == OP_LOAD);
          r_cnt_store  <= sat_inc(r_cnt_store, w_op == OP_STORE);
          r_cnt_jump   <= sat_inc(r_cnt_jump, (w_op == OP_JAL) || (w_op == OP_JALR));
          r_cnt_exc    <= sat_inc(r_cnt_exc, i_ret_exception);
          if (w_err_chk != 3'd0) begin
            r_err  <= w_err_chk;
            r_fidx <= r_checked;
          end else begin
            r_checked <= w_checked_inc;
          end
        end
      end else begin
        r_idle <= w_idle_inc;
        if (w_idle_inc == IW'(TIMEOUT_CYCLES)) begin
          r_err  <= 3'd6;
          r_fidx <= r_checked;
        end
      end
    end
  end

  assign o_busy       = (r_state == S_RUN);
  assign o_pass       = (r_state == S_PASS);
  assign o_fail       = (r_state == S_FAIL);
  assign o_timeout    = (r_state == S_TIMEOUT);
  assign o_err_code   = r_err;
  assign o_fail_index = r_fidx;
  assign o_cnt_instr  = r_cnt_instr;
  assign o_cnt_branch = r_cnt_branch;
  assign o_cnt_load   = r_cnt_load;
  assign o_cnt_store  = r_cnt_store;
  assign o_cnt_jump   = r_cnt_jump;
  assign o_cnt_exc    = r_cnt_exc;
endmodule

// File: tb/tb_tb_retire_checker.sv
// Bench for the retirement checker: directed scenarios plus randomized runs scored against a queue-based model.
module tb_tb_retire_checker;
  localparam int DEPTH     = 4;
  localparam int TMO       = 20;
  localparam int MAX_TESTS = 1000;
  localparam int CW        = $clog2(MAX_TESTS + 1);

  localparam logic [6:0] OP_ADDI = 7'b0010011, OP_ADD = 7'b0110011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam int P_IDLE = 0, P_RUN = 1, P_PASS = 2, P_FAIL = 3, P_TO = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] result;
    logic        exc;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [CW-1:0] num_tests = '0;
  logic exp_valid = 1'b0, exp_ready;
  logic [31:0] exp_instr = '0, exp_pc = '0, exp_result = '0;
  logic exp_exception = 1'b0;
  logic ret_valid = 1'b0;
  logic [31:0] ret_instr = '0, ret_pc = '0, ret_result = '0;
  logic ret_exception = 1'b0;
  logic busy, pass, fail, timeout;
  logic [2:0] err_code;
  logic [CW-1:0] fail_index;
  logic [31:0] cnt_instr, cnt_branch, cnt_load, cnt_store, cnt_jump, cnt_exc;

  int total = 0;
  int bad = 0;

  // Reference model state
  rec_t m_q[$];
  int m_phase, m_num, m_checked, m_idle, m_err, m_fidx;
  int unsigned m_cnt[6];

  always #5 clk = ~clk;

  tb_retire_checker #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .MAX_TESTS(MAX_TESTS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_tests(num_tests),
    .i_exp_valid(exp_valid), .o_exp_ready(exp_ready),
    .i_exp_instr(exp_instr), .i_exp_pc(exp_pc), .i_exp_result(exp_result), .i_exp_exception(exp_exception),
    .i_ret_valid(ret_valid), .i_ret_instr(ret_instr), .i_ret_pc(ret_pc), .i_ret_result(ret_result),
    .i_ret_exception(ret_exception),
    .o_busy(busy), .o_pass(pass), .o_fail(fail), .o_timeout(timeout),
    .o_err_code(err_code), .o_fail_index(fail_index),
    .o_cnt_instr(cnt_instr), .o_cnt_branch(cnt_branch), .o_cnt_load(cnt_load),
    .o_cnt_store(cnt_store), .o_cnt_jump(cnt_jump), .o_cnt_exc(cnt_exc)
  );

  task automatic model_reset();
    m_q.delete();
    m_phase = P_IDLE; m_num = 0; m_checked = 0; m_idle = 0; m_err = 0; m_fidx = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  function automatic int expect_err(rec_t e);
    logic [6:0] op;
    op = ret_instr[6:0];
    if (ret_pc != e.pc) return 1;
    if (ret_instr != e.instr) return 2;
    if (ret_exception != e.exc) return 3;
    if (op != OP_BRANCH && op != OP_STORE && !e.exc && ret_result != e.result) return 4;
    return 0;
  endfunction

  function automatic logic [3:0] exp_status();
    return {m_phase == P_RUN, m_phase == P_PASS, m_phase == P_FAIL, m_phase == P_TO};
  endfunction

  function automatic logic exp_rdy();
    return (m_phase == P_RUN) && (m_q.size() < DEPTH);
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic rdy;
    rec_t e;
    logic [6:0] op;
    int ec;
    rdy = exp_rdy();
    if (start) begin
      model_reset();
      m_num = (int'(num_tests) > MAX_TESTS) ? MAX_TESTS : int'(num_tests);
      m_phase = (m_num == 0) ? P_PASS : P_RUN;
      return;
    end
    if (m_phase != P_RUN) return;
    if (ret_valid) begin
      m_idle = 0;
      if (m_q.size() == 0) begin
        m_phase = P_FAIL; m_err = 5; m_fidx = m_checked;
      end else begin
        e = m_q.pop_front();
        op = ret_instr[6:0];
        m_cnt[0]++;
        if (op == OP_BRANCH) m_cnt[1]++;
        if (op == OP_LOAD) m_cnt[2]++;
        if (op == OP_STORE) m_cnt[3]++;
        if (op == OP_JAL || op == OP_JALR) m_cnt[4]++;
        if (ret_exception) m_cnt[5]++;
        ec = expect_err(e);
        if (ec != 0) begin
          m_phase = P_FAIL; m_err = ec; m_fidx = m_checked;
        end else begin
          m_checked++;
          if (m_checked == m_num) m_phase = P_PASS;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        m_phase = P_TO; m_err = 6; m_fidx = m_checked;
      end
    end
    if (exp_valid && rdy) m_q.push_back('{instr: exp_instr, pc: exp_pc, result: exp_result, exc: exp_exception});
  endtask

  // One clock: model consumes the current inputs, DUT samples them, outputs settle; pulse inputs drop.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    start = 1'b0;
    ret_valid = 1'b0;
  endtask

  function automatic rec_t make_rec(logic [6:0] op, logic exc);
    rec_t r;
    logic [31:0] w;
    w = $urandom;
    r.instr = {w[31:7], op};
    r.pc = $urandom & 32'hFFFF_FFFC;
    r.result = $urandom;
    r.exc = exc;
    return r;
  endfunction

  function automatic rec_t rand_rec();
    logic [6:0] ops [7];
    ops = '{OP_ADDI, OP_ADD, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
    return make_rec(ops[$urandom_range(0, 6)], $urandom_range(0, 7) == 0);
  endfunction

  task automatic set_exp(rec_t r);
    exp_instr = r.instr; exp_pc = r.pc; exp_result = r.result; exp_exception = r.exc;
  endtask

  task automatic drive_ret(rec_t r);
    ret_instr = r.instr; ret_pc = r.pc; ret_result = r.result; ret_exception = r.exc;
  endtask

  task automatic do_start(int n);
    num_tests = CW'(n);
    start = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    total++; if ({busy, pass, fail, timeout} !== 4'b0000) begin bad++; $display("FAIL reset_status got=%b want=0000", {busy, pass, fail, timeout}); end
    total++; if (exp_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", exp_ready); end
    total++; if (err_code !== 3'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_code); end
    total++; if (fail_index !== '0) begin bad++; $display("FAIL reset_fidx got=%0d want=0", fail_index); end
    total++; if ({cnt_instr, cnt_branch, cnt_load, cnt_store, cnt_jump, cnt_exc} !== '0) begin bad++; $display("FAIL reset_counters got=%0d want=0", cnt_instr); end
    // A retirement while idle must be ignored.
    drive_ret(rand_rec()); ret_valid = 1'b1; exp_valid = 1'b1;
    tick();
    exp_valid = 1'b0;
    total++; if (cnt_instr !== 32'd0 || busy !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL idle_ret_ignored cnt=%0d busy=%b fail=%b want 0/0/0", cnt_instr, busy, fail); end
  endtask

  task automatic test_basic_pass();
    rec_t recs [3];
    do_start(3);
    total++; if (busy !== 1'b1 || exp_ready !== 1'b1) begin bad++; $display("FAIL start_busy busy=%b ready=%b want 1/1", busy, exp_ready); end
    for (int i = 0; i < 3; i++) begin
      recs[i] = make_rec(OP_ADDI, 1'b0);
      set_exp(recs[i]); exp_valid = 1'b1;
      tick();
    end
    exp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (pass !== 1'b0) begin bad++; $display("FAIL early_pass i=%0d got=%b want=0", i, pass); end
      drive_ret(recs[i]); ret_valid = 1'b1;
      tick();
    end
    total++; if (pass !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_pass pass=%b busy=%b want 1/0", pass, busy); end
    total++; if (cnt_instr !== 32'd3) begin bad++; $display("FAIL basic_cnt_instr got=%0d want=3", cnt_instr); end
    total++; if ((cnt_branch | cnt_load | cnt_store | cnt_jump | cnt_exc) !== 32'd0) begin bad++; $display("FAIL basic_other_cnt got=%0d want=0", cnt_branch | cnt_load | cnt_store | cnt_jump | cnt_exc); end
    total++; if (err_code !== 3'd0) begin bad++; $display("FAIL basic_err got=%0d want=0", err_code); end
  endtask

  task automatic test_pc_mismatch();
    rec_t r0, r1;
    do_start(5);
    r0 = rand_rec(); r1 = rand_rec();
    set_exp(r0); exp_valid = 1'b1; tick();
    set_exp(r1); tick();
    exp_valid = 1'b0;
    drive_ret(r0); ret_valid = 1'b1; tick();
    r1.pc = r1.pc + 32'd4;
    drive_ret(r1); ret_valid = 1'b1; tick();
    total++; if (fail !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL pc_fail fail=%b busy=%b want 1/0", fail, busy); end
    total++; if (err_code !== 3'd1) begin bad++; $display("FAIL pc_err got=%0d want=1", err_code); end
    total++; if (fail_index !== CW'(1)) begin bad++; $display("FAIL pc_fidx got=%0d want=1", fail_index); end
    total++; if (cnt_instr !== 32'd2) begin bad++; $display("FAIL pc_cnt got=%0d want=2", cnt_instr); end
  endtask

  task automatic test_result_classes();
    rec_t st, ad;
    do_start(4);
    st = make_rec(OP_STORE, 1'b0); st.result = 32'h5;
    ad = make_rec(OP_ADD, 1'b0);   ad.result = 32'h5;
    set_exp(st); exp_valid = 1'b1; tick();
    set_exp(ad); tick();
    exp_valid = 1'b0;
    st.result = 32'h6; drive_ret(st); ret_valid = 1'b1; tick();
    total++; if (fail !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL store_result fail=%b busy=%b want 0/1", fail, busy); end
    ad.result = 32'h6; drive_ret(ad); ret_valid = 1'b1; tick();
    total++; if (fail !== 1'b1 || err_code !== 3'd4) begin bad++; $display("FAIL add_result fail=%b err=%0d want 1/4", fail, err_code); end
    total++; if (fail_index !== CW'(1) || cnt_store !== 32'd1) begin bad++; $display("FAIL add_result_idx fidx=%0d store=%0d want 1/1", fail_index, cnt_store); end
  endtask

  task automatic test_underflow();
    rec_t r;
    do_start(2);
    r = rand_rec();
    set_exp(r); exp_valid = 1'b1;
    drive_ret(r); ret_valid = 1'b1;
    tick();
    exp_valid = 1'b0;
    total++; if (fail !== 1'b1 || err_code !== 3'd5) begin bad++; $display("FAIL underflow fail=%b err=%0d want 1/5", fail, err_code); end
    total++; if (fail_index !== CW'(0)) begin bad++; $display("FAIL underflow_fidx got=%0d want=0", fail_index); end
  endtask

  task automatic test_start_priority();
    rec_t r;
    r = rand_rec();
    set_exp(r); exp_valid = 1'b1; drive_ret(r); ret_valid = 1'b1;
    do_start(2);
    exp_valid = 1'b0;
    total++; if (busy !== 1'b1 || cnt_instr !== 32'd0 || err_code !== 3'd0) begin bad++; $display("FAIL start_prio busy=%b cnt=%0d err=%0d want 1/0/0", busy, cnt_instr, err_code); end
    // The record offered with start must have been dropped, so this retirement underflows.
    drive_ret(r); ret_valid = 1'b1; tick();
    total++; if (err_code !== 3'd5) begin bad++; $display("FAIL start_drop_push err=%0d want=5", err_code); end
    do_start(0);
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL zero_tests pass=%b want=1", pass); end
  endtask

  task automatic test_full();
    rec_t extra;
    do_start(DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) begin
      set_exp(rand_rec()); exp_valid = 1'b1; tick();
    end
    total++; if (exp_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", exp_ready); end
    extra = rand_rec(); set_exp(extra); tick();
    total++; if (exp_ready !== 1'b0) begin bad++; $display("FAIL full_held got=%b want=0", exp_ready); end
    drive_ret(m_q[0]); ret_valid = 1'b1; tick();
    total++; if (exp_ready !== 1'b1) begin bad++; $display("FAIL after_pop_ready got=%b want=1", exp_ready); end
    tick();
    exp_valid = 1'b0;
    total++; if (exp_ready !== exp_rdy()) begin bad++; $display("FAIL refill_ready got=%b want=%b", exp_ready, exp_rdy()); end
    for (int i = 0; i < DEPTH && m_q.size() > 0; i++) begin
      drive_ret(m_q[0]); ret_valid = 1'b1; tick();
    end
    total++; if (pass !== 1'b1 || cnt_instr !== 32'(DEPTH + 1)) begin bad++; $display("FAIL full_pass pass=%b cnt=%0d want 1/%0d", pass, cnt_instr, DEPTH + 1); end
  endtask

  task automatic test_timeout();
    rec_t r;
    int waited;
    do_start(5);
    r = rand_rec(); set_exp(r); exp_valid = 1'b1; tick();
    exp_valid = 1'b0;
    drive_ret(r); ret_valid = 1'b1; tick();
    waited = 0;
    while (timeout !== 1'b1 && waited < 5 * TMO) begin
      tick(); waited++;
    end
    total++; if (waited !== TMO) begin bad++; $display("FAIL timeout_cycles got=%0d want=%0d", waited, TMO); end
    total++; if (err_code !== 3'd6 || fail_index !== CW'(1)) begin bad++; $display("FAIL timeout_info err=%0d fidx=%0d want 6/1", err_code, fail_index); end
    do_start(3);
    total++; if (busy !== 1'b1 || timeout !== 1'b0 || exp_ready !== 1'b1) begin bad++; $display("FAIL recover busy=%b to=%b ready=%b want 1/0/1", busy, timeout, exp_ready); end
    total++; if (cnt_instr !== 32'd0 || err_code !== 3'd0 || fail_index !== '0) begin bad++; $display("FAIL recover_clear cnt=%0d err=%0d fidx=%0d want 0/0/0", cnt_instr, err_code, fail_index); end
  endtask

  task automatic test_random();
    for (int trial = 0; trial < 4; trial++) begin
      int cyc, nret, fault_at;
      rec_t r;
      do_start($urandom_range(10, 30));
      fault_at = (trial >= 2) ? $urandom_range(0, 8) : -1;
      nret = 0; cyc = 0;
      while (m_phase == P_RUN && cyc < 3000) begin
        if ($urandom_range(0, 9) < 6) begin set_exp(rand_rec()); exp_valid = 1'b1; end
        else exp_valid = 1'b0;
        if (m_q.size() > 0 && $urandom_range(0, 1) == 1) begin
          r = m_q[0];
          if (nret == fault_at) begin
            case ($urandom_range(0, 3))
              0: r.pc = r.pc ^ 32'h4;
              1: r.instr = r.instr ^ 32'h0010_0000;
              2: r.exc = ~r.exc;
              default: r.result = r.result + 32'd1;
            endcase
          end
          drive_ret(r); ret_valid = 1'b1; nret++;
        end
        tick(); cyc++;
        total++; if ({busy, pass, fail, timeout} !== exp_status() || exp_ready !== exp_rdy()) begin bad++; $display("FAIL rand_status t=%0d c=%0d got=%b/%b want=%b/%b", trial, cyc, {busy, pass, fail, timeout}, exp_ready, exp_status(), exp_rdy()); end
        total++; if (err_code !== 3'(m_err) || fail_index !== CW'(m_fidx)) begin bad++; $display("FAIL rand_err t=%0d c=%0d got=%0d/%0d want=%0d/%0d", trial, cyc, err_code, fail_index, m_err, m_fidx); end
      end
      exp_valid = 1'b0;
      total++; if (m_phase == P_RUN) begin bad++; $display("FAIL rand_bound t=%0d run did not finish within %0d cycles", trial, cyc); end
      total++; if ({cnt_instr, cnt_branch, cnt_load} !== {m_cnt[0], m_cnt[1], m_cnt[2]}) begin bad++; $display("FAIL rand_cnt_a t=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", trial, cnt_instr, cnt_branch, cnt_load, m_cnt[0], m_cnt[1], m_cnt[2]); end
      total++; if ({cnt_store, cnt_jump, cnt_exc} !== {m_cnt[3], m_cnt[4], m_cnt[5]}) begin bad++; $display("FAIL rand_cnt_b t=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", trial, cnt_store, cnt_jump, cnt_exc, m_cnt[3], m_cnt[4], m_cnt[5]); end
    end
  endtask

  task automatic test_reset_midrun();
    rec_t r;
    do_start(10);
    r = rand_rec(); set_exp(r); exp_valid = 1'b1; tick();
    set_exp(rand_rec()); tick();
    exp_valid = 1'b0;
    drive_ret(r); ret_valid = 1'b1; tick();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (busy !== 1'b0 || exp_ready !== 1'b0 || cnt_instr !== 32'd0) begin bad++; $display("FAIL async_reset busy=%b ready=%b cnt=%0d want 0/0/0", busy, exp_ready, cnt_instr); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    do_start(2);
    drive_ret(r); ret_valid = 1'b1; tick();
    total++; if (err_code !== 3'd5) begin bad++; $display("FAIL reset_fifo_cleared err=%0d want=5", err_code); end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_pc_mismatch();
    test_result_classes();
    test_underflow();
    test_start_priority();
    test_full();
    test_timeout();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/tb_retire_checker.md
# tb_retire_checker

In-order retirement checker for the rv32 core bench; the consuming end of the test-stimulus stream. The stimulus generator pushes expected records (instr, pc, expected result, expected exception) into an internal FIFO; the core's retire port pops them one per retired instruction. Each retirement is compared field by field against its expected record, per-class statistics are accumulated, and the run ends in PASS, FAIL or TIMEOUT. Synthesizable, so it can also sit in the FPGA bring-up harness.

## Interface
Parameters:
- DEPTH, 16: expected-record FIFO depth, power of two ≥ 2.
- TIMEOUT_CYCLES, 10000: maximum idle cycles between retirements while running.
- MAX_TESTS, 1000: upper bound for num_tests; CW = $clog2(MAX_TESTS+1).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; latch num_tests, clear FIFO, counters and status, enter RUN.
- num_tests  in  CW  number of retirements to check; values above MAX_TESTS are clamped to MAX_TESTS.
- exp_valid  in  1  expected record valid.
- exp_ready  out  1  FIFO accepts a record.
- exp_instr, exp_pc, exp_result  in  32 each  expected fields.
- exp_exception  in  1  expected exception flag.
- ret_valid  in  1  core retired an instruction this cycle. No backpressure.
- ret_instr, ret_pc, ret_result  in  32 each  retired fields.
- ret_exception  in  1  retired instruction trapped.
- busy, pass, fail, timeout  out  1 each  status, one-hot with idle.
- err_code  out  3  0 none, 1 pc, 2 instr, 3 exception, 4 result, 5 underflow, 6 timeout.
- fail_index  out  CW  0-based index of the offending retirement.
- cnt_instr, cnt_branch, cnt_load, cnt_store, cnt_jump, cnt_exc  out  32 each  statistics.

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. Reset to IDLE. start from any state goes to RUN. PASS, FAIL and TIMEOUT hold until start.
- busy=1 only in RUN. Each of pass, fail and timeout is 1 only in its own state.
- FIFO push when exp_valid && exp_ready. exp_ready = RUN && !full. Records offered outside RUN are not accepted.
- Check when ret_valid in RUN. FIFO empty → FAIL with err 5. There is no bypass: a push in the same cycle does not satisfy the retirement.
- Otherwise pop the head and compare in priority order: pc, then instr, then exception, then result. First mismatch → FAIL with its err_code.
- The result is compared only when the retired opcode is not branch (1100011) or store (0100011) and exp_exception=0.
- On any completed check, including a failing one, increment the following:
  - cnt_instr always.
  - cnt_branch for opcode 1100011.
  - cnt_load for 0000011.
  - cnt_store for 0100011.
  - cnt_jump for 1101111 or 1100111.
  - cnt_exc when ret_exception=1.
- Opcode classification uses ret_instr[6:0].
- Counters saturate at 2^32-1.
- checked counter (CW bits) increments on each matching check. checked == num_tests → PASS. num_tests=0 → PASS on the cycle after start.
- fail_index = checked value at the failing check. It is 0 unless in FAIL or TIMEOUT; for TIMEOUT it equals checked.
- Idle counter resets on start and on every ret_valid in RUN, and increments otherwise in RUN. Reaching TIMEOUT_CYCLES → TIMEOUT with err 6.
- ret_valid outside RUN is ignored: no count, no state change.

## Timing
- Reset values:
  - state IDLE.
  - exp_ready, busy, pass, fail, timeout = 0.
  - err_code = 0, fail_index = 0.
  - All counters and the FIFO are cleared.
- start sampled at edge N: busy=1 from N+1, exp_ready=1 from N+1 if not full. Counters, err_code and fail_index read 0 from N+1.
- A record pushed at edge N is checkable by a retirement sampled at edge N+1 or later.
- Retirement sampled at edge N: the result is visible after edge N, on all status outputs and counters simultaneously.
  - Last matching retirement → pass=1 from N+1.
  - Mismatch → fail=1 from N+1.
- Push and pop in the same cycle are both performed. A full FIFO with a simultaneous pop still shows exp_ready=0 (registered full).
- Timeout: with the last retirement sampled at edge N, timeout=1 after edge N+TIMEOUT_CYCLES.
- start coinciding with ret_valid or exp_valid: start wins and the other input is dropped.
- rst_n asserted mid-run returns everything to reset values immediately.

## Test plan
- num_tests=3; push 3 matching ADDI records, then retire them → pass=1 one cycle after the 3rd retirement; cnt_instr=3, others 0; err_code=0.
- Push 2 records; retire the 2nd with ret_pc off by 4 → fail, err_code=1, fail_index=1, cnt_instr=2.
- Expected result 0x5, retired result 0x6, for a store, then for an ADD → store passes; ADD fails with err_code=4.
- ret_valid with an empty FIFO while exp_valid is asserted in the same cycle → fail, err_code=5, fail_index=0.
- Fill the FIFO with DEPTH records → exp_ready drops; the push offered during that drop is held by the source and accepted after the next pop.
- TIMEOUT_CYCLES=20; one retirement, then silence → timeout=1 exactly 20 cycles later with err_code=6; start then recovers to RUN with cleared counters.
